// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the convolution stream adapter.
package conv_pkg;

    localparam int DATA_W    = 32;
    localparam int IMG_N     = 5;
    localparam int K_N       = 3;
    localparam int OUT_N     = IMG_N - K_N + 1;

    localparam int IMG_WORDS = IMG_N * IMG_N;
    localparam int K_WORDS   = K_N * K_N;
    localparam int RES_WORDS = OUT_N * OUT_N;

    localparam int IMG_W     = DATA_W * IMG_WORDS;
    localparam int KER_W     = DATA_W * K_WORDS;
    localparam int RES_W     = DATA_W * RES_WORDS;

    typedef enum logic [1:0] {
        LOAD_K = 2'd0,
        LOAD_I = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } conv_state_t;

endpackage

// File: rtl/conv_stream_adapter_if.sv
// Input and output valid/ready word streams of the convolution adapter.
// slave: the adapter side; master: the DMA / downstream side.
interface conv_stream_adapter_if;

    logic [conv_pkg::DATA_W-1:0] s_data;
    logic                        s_valid;
    logic                        s_ready;
    logic [conv_pkg::DATA_W-1:0] m_data;
    logic                        m_valid;
    logic                        m_ready;
    logic                        m_last;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

endinterface

// File: rtl/word_serializer.sv
// Holds the captured 3x3 result and streams it out word 0 first, honouring
// downstream backpressure.
module word_serializer
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [RES_W-1:0]  res,
    input  logic              active,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    output logic              done
);

    localparam logic [3:0] LAST_IDX = 4'(RES_WORDS - 1);

    logic [RES_WORDS-1:0][DATA_W-1:0] res_q;
    logic [3:0]                       idx_q;

    // Capture the core result and walk the word index on each accepted word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            res_q <= res;
            idx_q <= '0;
        end else if (done) begin
            idx_q <= '0;
        end else if (m_valid && m_ready) begin
            idx_q <= idx_q + 4'd1;
        end
    end

    // Outputs depend only on registered state, so they hold while stalled.
    always_comb begin
        m_valid = rst_n && active;
        m_last  = m_valid && (idx_q == LAST_IDX);
        m_data  = m_valid ? res_q[LAST_IDX - idx_q] : '0;
        done    = m_valid && m_ready && m_last;
    end

endmodule

// File: rtl/conv_stream_adapter.sv
// Packs the serial kernel/image words for the convolution core, waits out the
// core latency, then streams the 3x3 result back. One job at a time.
module conv_stream_adapter
    import conv_pkg::*;
#(
    parameter int CONV_LAT = 8  // legal range 1..255 (8-bit wait counter)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    conv_stream_adapter_if.slave     strm,
    output logic [IMG_W-1:0]         image,
    output logic [KER_W-1:0]         kernal,
    output logic                     conv_start,
    input  logic [RES_W-1:0]         res,
    output logic                     busy
);

    localparam logic [4:0] K_LAST   = 5'(K_WORDS - 1);
    localparam logic [4:0] I_LAST   = 5'(IMG_WORDS - 1);
    localparam logic [3:0] K_TOP    = 4'(K_WORDS - 1);
    localparam logic [7:0] LAT_LAST = 8'(CONV_LAT - 1);

    conv_state_t state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  wait_q, wait_d;
    logic        start_d;
    logic        res_load;
    logic        drain_done;
    logic        s_hs;

    logic [K_WORDS-1:0][DATA_W-1:0]   kern_q;
    logic [IMG_WORDS-1:0][DATA_W-1:0] img_q;

    assign strm.s_ready = rst_n && (state_q == LOAD_K || state_q == LOAD_I);
    assign s_hs         = strm.s_valid && strm.s_ready;
    assign busy         = rst_n && !(state_q == LOAD_K && cnt_q == 5'd0);
    assign kernal       = kern_q;
    assign image        = img_q;

    // State, word counter, latency counter and the start pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LOAD_K;
            cnt_q      <= '0;
            wait_q     <= '0;
            conv_start <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            conv_start <= start_d;
        end
    end

    // Next-state logic: load kernel, load image, wait for core, drain result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        start_d  = 1'b0;
        res_load = 1'b0;
        unique case (state_q)
            LOAD_K: if (s_hs) begin
                if (cnt_q == K_LAST) begin
                    state_d = LOAD_I;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            LOAD_I: if (s_hs) begin
                if (cnt_q == I_LAST) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    wait_d  = '0;
                    start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            WAIT: begin
                if (wait_q == LAT_LAST) begin
                    res_load = 1'b1;
                    state_d  = DRAIN;
                    wait_d   = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DRAIN: if (drain_done) begin
                state_d = LOAD_K;
                cnt_d   = '0;
            end
            default: state_d = LOAD_K;
        endcase
    end

    // Core operand registers: written only by their own input handshakes,
    // word 0 of each group in the most significant slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kern_q <= '0;
            img_q  <= '0;
        end else begin
            if (state_q == LOAD_K && s_hs) kern_q[K_TOP - cnt_q[3:0]] <= strm.s_data;
            if (state_q == LOAD_I && s_hs) img_q[I_LAST - cnt_q]      <= strm.s_data;
        end
    end

    word_serializer u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (res_load),
        .res     (res),
        .active  (state_q == DRAIN),
        .m_ready (strm.m_ready),
        .m_data  (strm.m_data),
        .m_valid (strm.m_valid),
        .m_last  (strm.m_last),
        .done    (drain_done)
    );

endmodule

// File: doc/conv_stream_adapter.md
Name: conv_stream_adapter

Overview:
- Streaming front/back end for the 5x5-image / 3x3-kernel convolution core.
- Receives 32-bit IEEE-754 words serially over a valid/ready input stream and packs them into the flat image and kernel buses the core consumes.
- Waits a fixed core latency, captures the flat 3x3 result bus, and serialises it back out over a valid/ready output stream.
- Sits between the DMA/AXI-Stream side of the super-resolution datapath and the convolution core.

Parameters:
- DATA_W, 32, word width (single-precision float, treated as opaque bits)
- IMG_N, 5, image side length
- K_N, 3, kernel side length
- OUT_N, IMG_N-K_N+1 (=3), result side length; derived, not overridable
- CONV_LAT, 8, core latency in clk cycles from stable inputs to valid res; legal range 1..255

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- s_data  in  DATA_W  input word
- s_valid  in  1  input word valid
- s_ready  out  1  adapter accepts input word
- image  out  DATA_W*IMG_N*IMG_N  packed image to core
- kernal  out  DATA_W*K_N*K_N  packed kernel to core
- conv_start  out  1  one-cycle pulse when image/kernal become complete and stable
- res  in  DATA_W*OUT_N*OUT_N  packed result from core
- m_data  out  DATA_W  output result word
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts output word
- m_last  out  1  marks the 9th (final) result word
- busy  out  1  high in every state except LOAD_K with zero words received

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid and ready are both high.
- Input order per job: 9 kernel words, then 25 image words, row-major.
- Packing: word k of a group lands MSB-first. Kernel word 0 goes to kernal[287:256], kernel word 8 to kernal[31:0]. Image word 0 goes to image[799:768], image word 24 to image[31:0].
- Result order: res is unpacked the same way. m_data word 0 = res[287:256]; word 8 = res[31:0].
- FSM states:
  - LOAD_K (reset state): s_ready=1. Each handshake writes one kernel word; cnt increments. On handshake with cnt==8, go to LOAD_I with cnt=0.
  - LOAD_I: s_ready=1. Each handshake writes one image word. On handshake with cnt==24, go to WAIT with cnt=0, and conv_start=1 for the following cycle.
  - WAIT: s_ready=0. cnt increments every cycle. On the edge where cnt==CONV_LAT-1, latch res into the result register and go to DRAIN with cnt=0.
  - DRAIN: m_valid=1, m_data=result word[cnt], m_last=(cnt==8). On each m_ready handshake cnt increments. On handshake with m_last, go to LOAD_K with cnt=0.
- Latency: with the final image handshake at edge E, res is sampled at edge E+CONV_LAT, and m_valid is high from just after that edge.
- Backpressure: while m_ready=0, m_data, m_last and m_valid hold stable. s_valid is ignored outside LOAD_K and LOAD_I, and s_ready=0 there.
- Stability: image and kernal registers change only on their own input handshakes. They stay constant through WAIT and DRAIN and are retained into the next job until overwritten.
- Reset (any state, including mid-load or mid-drain), when rst_n=0 at an edge:
  - state=LOAD_K, cnt=0
  - image=0, kernal=0, result register=0
  - s_ready=0 during the reset cycle, 1 after it
  - m_valid=0, m_last=0, m_data=0, conv_start=0, busy=0
  - Partial jobs are discarded.
- No simultaneous input/output: the adapter never accepts input while draining. This is single-job, half-duplex.
- Width rule: cnt is 5 bits, enough for 0..24. The WAIT counter is 8 bits.

Decomposition:
- Shared package conv_pkg holds DATA_W, IMG_N, K_N, OUT_N, the flat bus widths, and the FSM state encoding (LOAD_K, LOAD_I, WAIT, DRAIN).
- One natural sub-module, word_serializer: holds the 9-word result register and drives m_data/m_valid/m_last with backpressure.

Test Plan:
- Reset then a 9+25 word load with kernel 3fc00000,3fa00000,3dcccccd,3f000000,3e800000,3e4ccccd,3e99999a,3ecccccd,3f000000 and image word0=3dcccccd … word24=3ef5c28f. Required: kernal=288'h3fc000003fa000003dcccccd3f0000003e8000003e4ccccd3e99999a3ecccccd3f000000, image[799:768]=3dcccccd, image[31:0]=3ef5c28f, conv_start pulses exactly once.
- Core stubbed so res words 0..8 = 00000001..00000009, CONV_LAT=8, m_ready=1. Required: m_valid rises after edge E+8, m_data sequence 1..9 on consecutive cycles, m_last only on 9, then s_ready=1.
- m_ready toggled 1-0-0-1 randomly during DRAIN. Required: no word lost or duplicated, m_data stable while stalled, 9 outputs total.
- rst_n pulsed low after 12 input words. Required: all outputs at reset values the next cycle. A fresh 34-word job then completes normally with no leftover data.
- s_valid held high during WAIT/DRAIN with changing s_data. Required: s_ready=0 and image/kernal unchanged.
- Two back-to-back jobs with different kernels. Required: second result reflects the second kernal, and busy is low only between jobs.
